// File: rtl/seq_div8.sv
// seq_div8: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Trial subtractions use a 4-bit-group carry-lookahead adder, so WIDTH must be a multiple of 4.
module seq_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] rem_r, q_r, div_r;
  logic [CW-1:0]    count;
  logic             accept, last;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next, q_next;

  // Returns {carry_out, low WIDTH bits of a + ~{1'b0, b} + 1}.
  // The lookahead runs over 4-bit groups; the zero-extended top bit of b
  // becomes an always-propagating position once inverted.
  function automatic logic [WIDTH:0] cla_sub(input logic [WIDTH:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g, p, c;
    logic             gc, grp_g, grp_p;
    g  = a[WIDTH-1:0] & ~b;
    p  = a[WIDTH-1:0] ^ ~b;
    c  = '0;
    gc = 1'b1;
    for (int k = 0; k < WIDTH / 4; k++) begin
      grp_g = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = &p[4*k +: 4];
      c[4*k]   = gc;
      c[4*k+1] = g[4*k] | (p[4*k] & gc);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc);
      gc = grp_g | (grp_p & gc);
    end
    return {a[WIDTH] | gc, p ^ c};
  endfunction

  assign trial  = cla_sub({rem_r, q_r[WIDTH-1]}, div_r);
  assign r_next = trial[WIDTH] ? trial[WIDTH-1:0] : {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
  assign q_next = {q_r[WIDTH-2:0], trial[WIDTH]};
  assign last   = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done   = (state == DONE);
        accept = start;
        if (start)              state_next = (divisor == '0) ? DONE : RUN;
        else if (state == DONE) state_next = IDLE;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results only move at a completion edge, so they stay stable through RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r       <= '0;
      q_r         <= '0;
      div_r       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        div_r <= divisor;
        rem_r <= '0;
        q_r   <= dividend;
        count <= '0;
      end
    end else if (state == RUN) begin
      rem_r <= r_next;
      q_r   <= q_next;
      count <= count + CW'(1);
      if (last) begin
        quotient    <= q_next;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: directed self-checking bench for seq_div8 using immediate assertions.
module tb_seq_div8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_div8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one start and follows the operation until done, a cycle budget, or an injected reset.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input int poke_at,
                                input int rst_at, output int lat, output int busy_n,
                                output logic stable);
    logic [7:0] held_q, held_r;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    held_q = quotient; held_r = remainder;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = b + 8'd3;
    lat = 0; busy_n = 0; stable = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if (quotient !== held_q || remainder !== held_r) stable = 1'b0;
      if (lat == rst_at) begin
        #2 rst = 1'b1;
        break;
      end
      if (lat == poke_at) begin start = 1'b1; dividend = 8'd9; divisor = 8'd3; end
      else if (lat == poke_at + 1) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                         input logic [7:0] er, input logic edbz, input int elat, input int poke_at);
    int   lat, busy_n;
    logic stable;
    string op;
    op = $sformatf("%0d/%0d", a, b);
    apply_stimulus(a, b, poke_at, -1, lat, busy_n, stable);
    check_output({op, " latency"}, lat, elat);
    check_output({op, " busy_cycles"}, busy_n, elat);
    check_output({op, " done"}, done, 1);
    check_output({op, " quotient"}, quotient, eq);
    check_output({op, " remainder"}, remainder, er);
    check_output({op, " div_by_zero"}, div_by_zero, edbz);
    check_output({op, " stable_in_run"}, stable, 1);
    if (b != 0) begin
      check_output({op, " reconstruct"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check_output({op, " rem_lt_div"}, remainder < b, 1);
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_output("idle done", done, 0);
      check_output("idle busy", busy, 0);
    end
  endtask

  initial begin
    int   lat, busy_n;
    logic stable;
    logic [7:0] ra, rb;

    #1;
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset quotient", quotient, 0);
    check_output("reset remainder", remainder, 0);
    check_output("reset div_by_zero", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;
    check_idle(2);

    $display("[TB] basic divide");
    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8, -1);
    check_idle(1);

    $display("[TB] back-to-back");
    run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8, -1);
    run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8, -1);

    $display("[TB] divide by zero then normal");
    run_div(8'd123, 8'd0, 8'hFF, 8'd123, 1'b1, 0, -1);
    run_div(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 8, -1);
    check_idle(1);
    check_output("dbz held", div_by_zero, 0);

    $display("[TB] start ignored while running");
    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8, 3);
    check_idle(4);

    $display("[TB] asynchronous reset mid-run");
    apply_stimulus(8'd250, 8'd3, -1, 4, lat, busy_n, stable);
    #1;
    check_output("async quotient", quotient, 0);
    check_output("async remainder", remainder, 0);
    check_output("async busy", busy, 0);
    check_output("async done", done, 0);
    check_output("async div_by_zero", div_by_zero, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check_idle(3);
    run_div(8'd250, 8'd3, 8'd83, 8'd1, 1'b0, 8, -1);

    $display("[TB] boundary operands");
    run_div(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 8, -1);
    run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8, -1);
    run_div(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 8, -1);
    run_div(8'd77, 8'd77, 8'd1, 8'd0, 1'b0, 8, -1);
    run_div(8'd255, 8'd2, 8'd127, 8'd1, 1'b0, 8, -1);
    run_div(8'd129, 8'd16, 8'd8, 8'd1, 1'b0, 8, -1);
    run_div(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 8, -1);
    run_div(8'd1, 8'd1, 8'd1, 8'd0, 1'b0, 8, -1);
    run_div(8'd0, 8'd255, 8'd0, 8'd0, 1'b0, 8, -1);

    $display("[TB] random operand pairs");
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run_div(ra, rb, ra / rb, ra % rb, 1'b0, 8, -1);
    end
    check_idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
